leve1_issue_ctrl: RTL
=====================

# leve1_issue_ctrl

Issue controller between the LEVE1 decode stage and the EX stage (`LEVE1_EX`). It decides each cycle whether the decoded instruction may enter EX. It tracks destination registers of long-latency operations in a scoreboard and stalls on RAW/WAW hazards. It serializes SYSTEM/CSR instructions behind a drained pipeline and honours EX redirect flushes.

## Interface
Parameters:
- MAX_INFLIGHT, 4: maximum outstanding long-latency operations.
- SER_GAP, 1: issue-blocked cycles after a serializing instruction issues (1..15).

Ports:
- CLK  in  1  clock; all state on posedge.
- RST  in  1  reset, synchronous, active-high.
- ID_VALID  in  1  decoded instruction present; held stable until accepted.
- ID_READY  out  1  instruction accepted this cycle (same signal as EX_VALID).
- ID_RS1, ID_RS2, ID_RD  in  5  register indices.
- ID_USE_RS1, ID_USE_RS2  in  1  source operand actually read.
- ID_WE  in  1  instruction writes ID_RD.
- ID_LONG  in  1  multi-cycle result (load); written back via LWB.
- ID_SERIAL  in  1  SYSTEM/CSR/MRET instruction; requires drained pipeline.
- EX_VALID  out  1  issue strobe to EX (drives EX IVALID).
- EX_READY  in  1  EX can accept.
- FLUSH  in  1  EX redirect (EX OFLASH); kills the instruction in ID.
- LWB_VALID  in  1  long-op writeback.
- LWB_RD  in  5  register written by the long op.
- INFLIGHT  out  3  outstanding long ops, $clog2(MAX_INFLIGHT+1) bits.
- BUSY  out  1  INFLIGHT != 0 or state != RUN.
- ERR  out  1  sticky protocol error.
- STALL_CNT  out  32  stall-cycle performance counter.

## Operation
- hazard = (USE_RS1 & RS1!=0 & sb[RS1]) | (USE_RS2 & RS2!=0 & sb[RS2]) | (WE & RD!=0 & sb[RD]).
- issue = ID_VALID & EX_READY & !FLUSH & !hazard & !(ID_LONG & INFLIGHT==MAX_INFLIGHT) & fsm_ok.
- ID_READY = EX_VALID = issue. The output is combinational, with no registered path from ID to EX inside this block.
- Scoreboard sb[31:1], with sb[0] fixed at 0.
  - issue & ID_LONG & ID_WE & RD!=0 sets sb[RD].
  - LWB_VALID clears sb[LWB_RD].
  - A set and a clear of the same index in one cycle cannot occur, because the WAW check blocks it. If it does occur, set wins.
- INFLIGHT increments on issue & ID_LONG and decrements on LWB_VALID; both together leave it unchanged.
  - LWB_VALID with INFLIGHT==0 sets ERR and leaves the counter at 0.
  - LWB_VALID to a register whose sb bit is clear also sets ERR.
- FSM (states RUN, DRAIN, SERIAL):
  - RUN, non-serial instruction: fsm_ok=1.
  - RUN, ID_VALID & ID_SERIAL: if INFLIGHT==0, fsm_ok=1, and when issued go to SERIAL with gap counter = SER_GAP. If INFLIGHT!=0, fsm_ok=0 and go to DRAIN.
  - DRAIN: fsm_ok=0. Go to RUN when INFLIGHT==0 (the serial instruction issues the following cycle at the earliest). FLUSH also returns to RUN.
  - SERIAL: fsm_ok=0. Decrement the counter each cycle and go to RUN when it reaches 0. FLUSH does not abort SERIAL, because the instruction has already issued.
- FLUSH never alters the scoreboard or INFLIGHT; already-issued long ops still write back.
- STALL_CNT increments when ID_VALID & !issue & !FLUSH, and wraps at 2^32.

## Timing
- Reset values: sb=0, INFLIGHT=0, state RUN, gap counter 0, ERR=0, STALL_CNT=0. Combinational outputs follow from this state (ID_READY/EX_VALID=0 when ID_VALID=0; BUSY=0).
- RST is sampled at posedge and overrides every other input that cycle. A reset during DRAIN or SERIAL returns to RUN next cycle, and in-flight LWB arriving after reset raises ERR.
- Issue latency is 0 cycles from inputs to EX_VALID.
- Scoreboard set and clear become visible the cycle after the event; there is no LWB bypass. A consumer of a load issues at the earliest one cycle after its LWB_VALID.
- A serial instruction issues at the earliest one cycle after INFLIGHT reaches 0. The next instruction issues at the earliest SER_GAP+1 cycles after the serial issue.

## Structure
- leve1_pkg holds:
  - issue_state_t enum {RUN, DRAIN, SERIAL};
  - regidx_t (logic [4:0]);
  - constant REG_ZERO.
- Sub-module leve1_scoreboard contains the 31 valid bits, the set/clear ports and two read ports plus the rd port. It exposes three hazard bits and an error bit.
- Top level holds the FSM, the INFLIGHT counter, the gap counter and STALL_CNT.

## Test plan
- Load x5 issues (ID_LONG, RD=5). Next cycle an ADD uses RS1=5 → EX_VALID=0 until the cycle after LWB_VALID/LWB_RD=5; STALL_CNT counts the stall cycles.
- Four loads issue back-to-back with MAX_INFLIGHT=4. A fifth load → stalls with INFLIGHT=4. One LWB → the fifth load issues the next cycle and INFLIGHT stays 4.
- CSRRW with 2 loads outstanding → state DRAIN and ID_READY=0. After both LWBs, the CSR issues one cycle after INFLIGHT=0. With SER_GAP=1, the following ADDI issues 2 cycles after the CSR.
- DRAIN with FLUSH asserted → state RUN next cycle, no issue that cycle, sb and INFLIGHT unchanged.
- LWB_VALID with INFLIGHT=0 → ERR=1 and stays 1; RST clears it along with STALL_CNT=0.
- Instruction using RS1=0 while LWB targets x0 → no hazard, issues in the same cycle, sb[0] stays 0.

Source files
------------

// File: rtl/leve1_pkg.sv
// Shared types for the LEVE1 issue controller.
//   issue_state_t : issue FSM states (RUN, DRAIN, SERIAL)
//   regidx_t      : architectural register index
//   REG_ZERO      : hard-wired zero register index
package leve1_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SERIAL = 2'd2
    } issue_state_t;

    typedef logic [4:0] regidx_t;

    localparam regidx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/leve1_scoreboard.sv
// Pending-write scoreboard for long-latency destinations (x1..x31).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   set_en/set_idx     : mark a register as pending (long op issued)
//   clr_en/clr_idx     : long-op writeback releases a register
//   rs1/rs2/rd_idx     : lookup indices of the instruction in ID
//   rs1/rs2/rd_busy    : pending bit of each looked-up register (x0 always 0)
//   clr_err            : writeback to a register that was not pending
module leve1_scoreboard
    import leve1_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    set_en,
    input  regidx_t set_idx,
    input  logic    clr_en,
    input  regidx_t clr_idx,
    input  regidx_t rs1_idx,
    input  regidx_t rs2_idx,
    input  regidx_t rd_idx,
    output logic    rs1_busy,
    output logic    rs2_busy,
    output logic    rd_busy,
    output logic    clr_err
);

    logic [31:1] sb;
    logic [31:0] sb_full;

    // x0 is never pending; widening with a zero LSB keeps lookups uniform.
    assign sb_full  = {sb, 1'b0};
    assign rs1_busy = sb_full[rs1_idx];
    assign rs2_busy = sb_full[rs2_idx];
    assign rd_busy  = sb_full[rd_idx];
    assign clr_err  = clr_en & ~sb_full[clr_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                // Set has priority over a same-cycle clear.
                if (set_en && set_idx == regidx_t'(i))
                    sb[i] <= 1'b1;
                else if (clr_en && clr_idx == regidx_t'(i))
                    sb[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/leve1_issue_ctrl.sv
// Issue controller between LEVE1 decode and EX. Decides combinationally
// whether the instruction in ID enters EX this cycle: stalls on RAW/WAW
// against pending long-op destinations, caps outstanding long ops, and
// serialises SYSTEM/CSR instructions behind a drained pipeline.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   ID_*                : decoded instruction and its handshake (ID_READY)
//   EX_VALID, EX_READY  : issue strobe / EX back-pressure
//   FLUSH               : EX redirect, kills the instruction in ID
//   LWB_VALID, LWB_RD   : long-op writeback
//   INFLIGHT            : outstanding long ops
//   BUSY, ERR, STALL_CNT: status, sticky protocol error, stall counter
module leve1_issue_ctrl
    import leve1_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int SER_GAP      = 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              ID_VALID,
    output logic                              ID_READY,
    input  logic [4:0]                        ID_RS1,
    input  logic [4:0]                        ID_RS2,
    input  logic [4:0]                        ID_RD,
    input  logic                              ID_USE_RS1,
    input  logic                              ID_USE_RS2,
    input  logic                              ID_WE,
    input  logic                              ID_LONG,
    input  logic                              ID_SERIAL,
    output logic                              EX_VALID,
    input  logic                              EX_READY,
    input  logic                              FLUSH,
    input  logic                              LWB_VALID,
    input  logic [4:0]                        LWB_RD,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] INFLIGHT,
    output logic                              BUSY,
    output logic                              ERR,
    output logic [31:0]                       STALL_CNT
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    issue_state_t state_q, state_d;
    logic [3:0]   gap_q, gap_d;
    logic         fsm_ok, hazard, full, issue_pre, issue;
    logic         rs1_busy, rs2_busy, rd_busy, sb_err;
    logic         inc, dec, inflight_zero;

    leve1_scoreboard u_sb (
        .clk     (CLK),
        .rst     (RST),
        .set_en  (issue & ID_LONG & ID_WE & (ID_RD != REG_ZERO)),
        .set_idx (ID_RD),
        .clr_en  (LWB_VALID),
        .clr_idx (LWB_RD),
        .rs1_idx (ID_RS1),
        .rs2_idx (ID_RS2),
        .rd_idx  (ID_RD),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .rd_busy (rd_busy),
        .clr_err (sb_err)
    );

    assign hazard = (ID_USE_RS1 & (ID_RS1 != REG_ZERO) & rs1_busy)
                  | (ID_USE_RS2 & (ID_RS2 != REG_ZERO) & rs2_busy)
                  | (ID_WE      & (ID_RD  != REG_ZERO) & rd_busy);

    assign inflight_zero = (INFLIGHT == '0);
    assign full          = ID_LONG & (INFLIGHT == IW'(MAX_INFLIGHT));

    // Everything except the FSM gate; kept separate so the next-state
    // logic can look at it without a false combinational loop via fsm_ok.
    assign issue_pre = ID_VALID & EX_READY & ~FLUSH & ~hazard & ~full;
    assign issue     = issue_pre & fsm_ok;
    assign ID_READY  = issue;
    assign EX_VALID  = issue;

    assign BUSY = ~inflight_zero | (state_q != RUN);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        fsm_ok  = 1'b0;
        case (state_q)
            RUN: begin
                fsm_ok = 1'b1;
                if (ID_VALID && ID_SERIAL) begin
                    if (inflight_zero) begin
                        if (issue_pre) begin
                            state_d = SERIAL;
                            gap_d   = 4'(SER_GAP);
                        end
                    end else begin
                        fsm_ok  = 1'b0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (FLUSH || inflight_zero)
                    state_d = RUN;
            end
            SERIAL: begin
                // Already issued, so FLUSH does not cut the gap short.
                gap_d = gap_q - 4'd1;
                if (gap_q <= 4'd1)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign inc = issue & ID_LONG;
    assign dec = LWB_VALID;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= RUN;
            gap_q     <= '0;
            INFLIGHT  <= '0;
            ERR       <= 1'b0;
            STALL_CNT <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            if (inc && !dec)
                INFLIGHT <= INFLIGHT + IW'(1);
            else if (dec && !inc && !inflight_zero)
                INFLIGHT <= INFLIGHT - IW'(1);
            if ((LWB_VALID && inflight_zero) || sb_err)
                ERR <= 1'b1;
            if (ID_VALID && !issue && !FLUSH)
                STALL_CNT <= STALL_CNT + 32'd1;
        end
    end

endmodule
